// File: rtl/mod_n_cntr_pkg.sv
// Shared constants and the wrapping next-value function for mod_n_cntr.
package mod_n_cntr_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_N     = 6;

    // Any out-of-range value recovers to 0, whatever the direction.
    function automatic logic [31:0] next_count(
        input logic [31:0] q,
        input logic        up,
        input logic [31:0] n
    );
        logic [31:0] result;
        if (q >= n) begin
            result = 32'd0;
        end else if (up == DIR_UP) begin
            result = (q == n - 32'd1) ? 32'd0 : q + 32'd1;
        end else begin
            result = (q == 32'd0) ? n - 32'd1 : q - 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_n_cntr.sv
// Modulo-N up/down counter with enable and asynchronous active-high reset.
// Optional terminal-count output o_tc is enabled by defining MOD_N_CNTR_TC_EN.
module mod_n_cntr
    import mod_n_cntr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up_down,
`ifdef MOD_N_CNTR_TC_EN
    output logic             o_tc,
`endif
    output logic [WIDTH-1:0] o_Q
);

    if (N < 2 || N > (1 << WIDTH)) begin : g_param_check
        $error("mod_n_cntr: N=%0d must satisfy 2 <= N <= 2**WIDTH (WIDTH=%0d)", N, WIDTH);
    end

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    assign q_next = WIDTH'(next_count(32'(q_reg), i_up_down, 32'(N)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_reg <= '0;
        end else if (i_en) begin
            q_reg <= q_next;
        end
    end

    assign o_Q = q_reg;

`ifdef MOD_N_CNTR_TC_EN
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(N - 1);

    // Gated by reset so a held reset (q=0, down) never reports a wrap.
    assign o_tc = ~i_rst & i_en &
                  ((i_up_down & (q_reg == Q_MAX)) |
                   (~i_up_down & (q_reg == '0)));
`endif

endmodule

// File: tb/tb_mod_n_cntr.sv
// Directed self-checking bench for mod_n_cntr at WIDTH=3, N=6.
// Checks o_tc too when MOD_N_CNTR_TC_EN is defined.
module tb_mod_n_cntr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b1;
    logic [2:0] q;
`ifdef MOD_N_CNTR_TC_EN
    logic       tc;
`endif

    int vectors = 0;
    int miscompares = 0;

    mod_n_cntr #(.WIDTH(3), .N(6)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_up_down (up_down),
`ifdef MOD_N_CNTR_TC_EN
        .o_tc      (tc),
`endif
        .o_Q       (q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] expected);
        vectors++;
        assert (q === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed q=%0d expected q=%0d", tag, q, expected);
        end
        $display("[%0t] %s: q=%0d (expect %0d)", $time, tag, q, expected);
    endtask

`ifdef MOD_N_CNTR_TC_EN
    task automatic chk_tc(input string tag, input logic expected);
        vectors++;
        assert (tc === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed tc=%0b expected tc=%0b", tag, tc, expected);
        end
        $display("[%0t] %s: tc=%0b (expect %0b)", $time, tag, tc, expected);
    endtask
`endif

    initial begin
        // 1: asynchronous reset at t=10, between edges, held for two edges
        #10;
        rst = 1'b1;
        #1;
        chk("rst_async", 3'd0);
        en = 1'b1;
        up_down = 1'b1;
        tick(); chk("rst_hold0", 3'd0);
        tick(); chk("rst_hold1", 3'd0);
        #2;
        rst = 1'b0;

        // 2: up count
        tick(); chk("up1", 3'd1);
        tick(); chk("up2", 3'd2);
        tick(); chk("up3", 3'd3);
        tick(); chk("up4", 3'd4);
        tick(); chk("up5", 3'd5);

        // 3: hold with direction toggling
        en = 1'b0;
        up_down = 1'b0;
        tick(); chk("hold0", 3'd5);
        up_down = 1'b1;
        tick(); chk("hold1", 3'd5);

        // 4: down count with wrap through 0
        en = 1'b1;
        up_down = 1'b0;
        tick(); chk("dn4", 3'd4);
        tick(); chk("dn3", 3'd3);
        tick(); chk("dn2", 3'd2);
        tick(); chk("dn1", 3'd1);
        tick(); chk("dn0", 3'd0);
        tick(); chk("dn_wrap5", 3'd5);
        tick(); chk("dn4b", 3'd4);
        tick(); chk("dn3b", 3'd3);
        tick(); chk("dn2b", 3'd2);
        tick(); chk("dn1b", 3'd1);

        // 5: back up to 4, wrap up, flip direction, wrap down
        up_down = 1'b1;
        tick(); chk("re_up2", 3'd2);
        tick(); chk("re_up3", 3'd3);
        tick(); chk("re_up4", 3'd4);
`ifdef MOD_N_CNTR_TC_EN
        chk_tc("tc_up_q4", 1'b0);
`endif
        tick(); chk("wrap_up5", 3'd5);
`ifdef MOD_N_CNTR_TC_EN
        chk_tc("tc_up_q5", 1'b1);
`endif
        tick(); chk("wrap_up0", 3'd0);
`ifdef MOD_N_CNTR_TC_EN
        chk_tc("tc_up_q0", 1'b0);
`endif
        tick(); chk("wrap_up1", 3'd1);
        up_down = 1'b0;
`ifdef MOD_N_CNTR_TC_EN
        chk_tc("tc_dn_q1", 1'b0);
`endif
        tick(); chk("flip_dn0", 3'd0);
`ifdef MOD_N_CNTR_TC_EN
        chk_tc("tc_dn_q0", 1'b1);
`endif
        tick(); chk("flip_dn5", 3'd5);
`ifdef MOD_N_CNTR_TC_EN
        chk_tc("tc_dn_q5", 1'b0);
        en = 1'b0;
        up_down = 1'b1;
        #1;
        chk_tc("tc_en0_q5", 1'b0);
`endif

        // 6: asynchronous reset mid-count at Q=3, then restart upward
        en = 1'b1;
        up_down = 1'b0;
        tick(); chk("pre_rst4", 3'd4);
        tick(); chk("pre_rst3", 3'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst", 3'd0);
`ifdef MOD_N_CNTR_TC_EN
        chk_tc("tc_in_rst", 1'b0);
`endif
        #2;
        rst = 1'b0;
        up_down = 1'b1;
        tick(); chk("restart1", 3'd1);
        tick(); chk("restart2", 3'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
